// File: rtl/split_slave_ctrl.sv
// Transaction controller for the split-capable slave: sequences one memory
// access per received request and drives the split handshake toward the arbiter.
module split_slave_ctrl #(
    parameter int ADDR_WIDTH    = 12,
    parameter int DATA_WIDTH    = 8,
    parameter int SPLIT_LATENCY = 4,
    parameter int SPLIT_EN      = 1,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  split_grant,
    output logic                  ssplit,
    output logic                  sready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_WAIT,
        S_DONE,
        S_RESP
    } state_t;

    localparam logic [7:0] LAT_LOAD = 8'(SPLIT_LATENCY);
    localparam logic [7:0] TMO_LAST = 8'(GRANT_TIMEOUT - 1);
    localparam bit         SPLIT_ON = (SPLIT_EN != 0);

    state_t                r_state;
    logic [7:0]            r_cnt;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_err;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_rdata <= '0;
            r_err       <= 1'b0;
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_mem_addr  <= req_addr;
                        r_mem_wdata <= req_wdata;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= req_write;
                        if (req_write) begin
                            r_state <= S_WR;
                        end else begin
                            r_state <= S_RD_WAIT;
                            r_cnt   <= LAT_LOAD;
                        end
                    end
                end
                S_WR: r_state <= S_RESP;
                S_RD_WAIT: begin
                    // Counter hits zero exactly in the cycle mem_rdata is valid.
                    if (r_cnt == 8'd0) begin
                        r_rsp_rdata <= mem_rdata;
                        r_state     <= SPLIT_ON ? S_DONE : S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    if (split_grant) begin
                        r_state <= S_RESP;
                    end else if (r_cnt == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Handshake flags decode the registered state only; no input reaches them.
    assign sready    = (r_state == S_IDLE);
    assign ssplit    = SPLIT_ON && (r_state == S_RD_WAIT);
    assign rsp_valid = (r_state == S_RESP);
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rsp_rdata = r_rsp_rdata;
    assign err       = r_err;

endmodule

// File: tb/tb_split_slave_ctrl.sv
// Bench for split_slave_ctrl: a split and a non-split instance share stimulus and
// are compared every cycle against a timestamp-based transaction model.
module tb_split_slave_ctrl;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int L  = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          split_grant;
    logic [DW-1:0] mem_rdata;

    // Index 0: SPLIT_EN=1 instance, index 1: SPLIT_EN=0 instance.
    logic          o_ssplit    [2];
    logic          o_sready    [2];
    logic          o_mem_en    [2];
    logic          o_mem_we    [2];
    logic [AW-1:0] o_mem_addr  [2];
    logic [DW-1:0] o_mem_wdata [2];
    logic          o_rsp_valid [2];
    logic [DW-1:0] o_rsp_rdata [2];
    logic          o_err       [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    split_slave_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SPLIT_LATENCY(L), .SPLIT_EN(1), .GRANT_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .split_grant(split_grant),
        .ssplit(o_ssplit[0]), .sready(o_sready[0]), .mem_en(o_mem_en[0]), .mem_we(o_mem_we[0]),
        .mem_addr(o_mem_addr[0]), .mem_wdata(o_mem_wdata[0]), .mem_rdata(mem_rdata),
        .rsp_valid(o_rsp_valid[0]), .rsp_rdata(o_rsp_rdata[0]), .err(o_err[0])
    );

    split_slave_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SPLIT_LATENCY(L), .SPLIT_EN(0), .GRANT_TIMEOUT(TO)
    ) dut_nosplit (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .split_grant(split_grant),
        .ssplit(o_ssplit[1]), .sready(o_sready[1]), .mem_en(o_mem_en[1]), .mem_we(o_mem_we[1]),
        .mem_addr(o_mem_addr[1]), .mem_wdata(o_mem_wdata[1]), .mem_rdata(mem_rdata),
        .rsp_valid(o_rsp_valid[1]), .rsp_rdata(o_rsp_rdata[1]), .err(o_err[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        check(name, 64'(act), 64'(exp));
    endtask

    // Transaction model: each accepted request is a timestamp t; every output
    // follows from t, L, TO and the first in-window grant cycle g.
    bit            m_rec   [2];
    bit            m_wr    [2];
    int            m_t0    [2];
    int            m_g     [2];
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    logic [DW-1:0] m_rdata [2];

    always @(negedge clk) begin : model
        int t;
        int d;
        bit se, busy, x_split, x_en, x_we, x_rv, x_err;
        logic [63:0] act;
        logic [63:0] exp;
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                m_rec[i]   = 1'b0;
                m_addr[i]  = '0;
                m_wdata[i] = '0;
                m_rdata[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                se = (i == 0);
                t = m_t0[i];
                d = t + 2 + L;
                busy = 1'b0; x_split = 1'b0; x_en = 1'b0; x_we = 1'b0; x_rv = 1'b0; x_err = 1'b0;
                if (m_rec[i]) begin
                    x_en = (cyc == t + 1);
                    if (m_wr[i]) begin
                        busy = (cyc <= t + 2);
                        x_we = x_en;
                        x_rv = (cyc == t + 2);
                    end else begin
                        x_split = se && (cyc >= t + 1) && (cyc <= t + 1 + L);
                        if (!se) begin
                            busy = (cyc <= t + 2 + L);
                            x_rv = (cyc == t + 2 + L);
                        end else if (m_g[i] >= 0) begin
                            busy = (cyc <= m_g[i] + 1);
                            x_rv = (cyc == m_g[i] + 1);
                        end else begin
                            busy  = (cyc < d + TO);
                            x_err = (cyc == d + TO);
                        end
                    end
                end
                act = 64'({o_ssplit[i], o_sready[i], o_mem_en[i], o_mem_we[i], o_rsp_valid[i],
                           o_err[i], o_mem_addr[i], o_mem_wdata[i], o_rsp_rdata[i]});
                exp = 64'({x_split, !busy, x_en, x_we, x_rv, x_err, m_addr[i], m_wdata[i], m_rdata[i]});
                check($sformatf("model dut%0d cycle %0d", i, cyc), act, exp);
                if (m_rec[i] && !m_wr[i] && cyc == t + 1 + L) m_rdata[i] = mem_rdata;
                if (m_rec[i] && !m_wr[i] && se && m_g[i] < 0 && cyc >= d && cyc < d + TO && split_grant)
                    m_g[i] = cyc;
                if (!busy && req_valid) begin
                    m_rec[i]   = 1'b1;
                    m_t0[i]    = cyc;
                    m_wr[i]    = req_write;
                    m_g[i]     = -1;
                    m_addr[i]  = req_addr;
                    m_wdata[i] = req_wdata;
                end
            end
        end
    end

    task automatic cyc_begin();
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        req_write   = 1'($urandom_range(0, 1));
        req_addr    = AW'($urandom);
        req_wdata   = DW'($urandom);
        split_grant = 1'b0;
        mem_rdata   = DW'($urandom);
    endtask

    int            rr_rsp   [2];
    int            rr_nrsp  [2];
    int            rr_nsplit[2];
    logic [DW-1:0] rr_rdata [2];
    int            rr_err, rr_nerr, rr_memen, rr_split_first, rr_split_last;
    bit            rr_sready_err;

    // One read transaction over an 80-cycle window, relative cycle 0 = req_valid.
    task automatic run_read(input logic [DW-1:0] data, input int grant_at, input int extra_req_at);
        for (int i = 0; i < 2; i++) begin
            rr_rsp[i] = -1; rr_nrsp[i] = 0; rr_nsplit[i] = 0; rr_rdata[i] = '0;
        end
        rr_err = -1; rr_nerr = 0; rr_memen = 0; rr_split_first = -1; rr_split_last = -1;
        rr_sready_err = 1'b0;
        for (int c = 0; c < 80; c++) begin
            cyc_begin();
            if (c == 0) begin req_valid = 1'b1; req_write = 1'b0; end
            if (c == extra_req_at) begin req_valid = 1'b1; req_write = 1'b1; end
            if (c == 1 + L) mem_rdata = data;
            if (c == grant_at) split_grant = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (o_rsp_valid[i] === 1'b1) begin
                    if (rr_rsp[i] < 0) begin rr_rsp[i] = c; rr_rdata[i] = o_rsp_rdata[i]; end
                    rr_nrsp[i]++;
                end
                if (o_ssplit[i] === 1'b1) rr_nsplit[i]++;
            end
            if (o_ssplit[0] === 1'b1) begin
                if (rr_split_first < 0) rr_split_first = c;
                rr_split_last = c;
            end
            if (o_mem_en[0] === 1'b1) rr_memen++;
            if (o_err[0] === 1'b1) begin
                if (rr_err < 0) begin rr_err = c; rr_sready_err = o_sready[0]; end
                rr_nerr++;
            end
        end
    endtask

    int quiet_hits;

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; split_grant = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_int($sformatf("reset sready dut%0d", i), int'(o_sready[i]), 1);
            check($sformatf("reset others dut%0d", i),
                  64'({o_ssplit[i], o_mem_en[i], o_mem_we[i], o_rsp_valid[i], o_err[i],
                       o_mem_addr[i], o_mem_wdata[i], o_rsp_rdata[i]}), 64'd0);
        end
        cyc_begin();
        rstn = 1'b1;
        repeat (2) cyc_begin();

        // Write 0x123 / 0xA5.
        cyc_begin();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h123; req_wdata = 8'hA5;
        @(negedge clk);
        check_int("wr c0 sready", int'(o_sready[0]), 1);
        cyc_begin();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("wr c1 dut%0d en/we/split/ready", i),
                  64'({o_mem_en[i], o_mem_we[i], o_ssplit[i], o_sready[i]}), 64'(4'b1100));
            check($sformatf("wr c1 dut%0d addr", i), 64'(o_mem_addr[i]), 64'h123);
            check($sformatf("wr c1 dut%0d wdata", i), 64'(o_mem_wdata[i]), 64'hA5);
        end
        cyc_begin();
        @(negedge clk);
        check("wr c2 rsp/ready/split", 64'({o_rsp_valid[0], o_sready[0], o_ssplit[0]}), 64'(3'b100));
        cyc_begin();
        @(negedge clk);
        check("wr c3 rsp/ready", 64'({o_rsp_valid[0], o_sready[0]}), 64'(2'b01));
        repeat (2) cyc_begin();

        // Read 0x3C, grant at 9, stray req_valid during RD_WAIT.
        run_read(8'h3C, 9, 2);
        check_int("rd rsp cycle", rr_rsp[0], 10);
        check_int("rd rsp data", int'(rr_rdata[0]), 'h3C);
        check_int("rd rsp count", rr_nrsp[0], 1);
        check_int("rd mem_en count", rr_memen, 1);
        check_int("rd ssplit first", rr_split_first, 1);
        check_int("rd ssplit last", rr_split_last, 5);
        check_int("rd ssplit cycles", rr_nsplit[0], 5);
        check_int("rd err count", rr_nerr, 0);
        check_int("nosplit rsp cycle", rr_rsp[1], 6);
        check_int("nosplit rsp data", int'(rr_rdata[1]), 'h3C);
        check_int("nosplit ssplit cycles", rr_nsplit[1], 0);

        // No grant: timeout 64 cycles after DONE entry (cycle 6).
        run_read(8'h5A, -1, -1);
        check_int("tmo err cycle", rr_err, 70);
        check_int("tmo err count", rr_nerr, 1);
        check_int("tmo sready at err", int'(rr_sready_err), 1);
        check_int("tmo rsp count", rr_nrsp[0], 0);

        // Grant on the last DONE cycle wins over timeout.
        run_read(8'h77, 69, -1);
        check_int("edge rsp cycle", rr_rsp[0], 70);
        check_int("edge rsp data", int'(rr_rdata[0]), 'h77);
        check_int("edge err count", rr_nerr, 0);

        // split_grant while idle is ignored.
        quiet_hits = 0;
        for (int c = 0; c < 6; c++) begin
            cyc_begin();
            if (c == 2) split_grant = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                if (o_rsp_valid[i] !== 1'b0 || o_err[i] !== 1'b0 || o_mem_en[i] !== 1'b0) quiet_hits++;
        end
        check_int("idle grant ignored", quiet_hits, 0);

        // Reset during a split read at cycle 3.
        cyc_begin();
        req_valid = 1'b1; req_write = 1'b0;
        repeat (2) cyc_begin();
        cyc_begin();
        rstn = 1'b0;
        #1;
        check("midrst split/ready", 64'({o_ssplit[0], o_sready[0]}), 64'(2'b01));
        check("midrst rsp_rdata", 64'(o_rsp_rdata[0]), 64'd0);
        cyc_begin();
        rstn = 1'b1;
        quiet_hits = 0;
        for (int c = 5; c < 16; c++) begin
            cyc_begin();
            if (c == 7 || c == 9) split_grant = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                if (o_rsp_valid[i] !== 1'b0 || o_err[i] !== 1'b0 || o_mem_en[i] !== 1'b0) quiet_hits++;
        end
        check_int("post-reset grant ignored", quiet_hits, 0);
        run_read(8'hC3, 9, -1);
        check_int("post-reset rsp cycle", rr_rsp[0], 10);
        check_int("post-reset rsp data", int'(rr_rdata[0]), 'hC3);

        // Random traffic: frequent grants, then rare grants so timeouts occur.
        for (int n = 0; n < 2000; n++) begin
            cyc_begin();
            req_valid   = ($urandom_range(0, 3) == 0);
            split_grant = ($urandom_range(0, 9) == 0);
        end
        for (int n = 0; n < 2000; n++) begin
            cyc_begin();
            req_valid   = ($urandom_range(0, 2) == 0);
            split_grant = ($urandom_range(0, 99) == 0);
        end
        cyc_begin();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
